alu_seq: RTL and testbench

- Arithmetic/logic stage directly downstream of the register file; operands A and B come from RF outputs O1/O2.
- Executes 15 single-cycle operations plus a multi-cycle unsigned shift-add multiply.
- Output and a Z/C/N/O flag register are registered.
- OutALU feeds back to the RF input bus and to the memory/address path.

---
 rtl/alu_seq.sv | 198 +++++++++++++++++++
 tb/tb_alu_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: RF-fed ALU with 15 single-cycle ops, shift-add unsigned MUL, registered Z/C/N/O flags.
// Latency: 1 cycle for single-cycle ops, NBits cycles for MUL; done pulses once per result.
// Backpressure: busy is high during MUL and start is ignored while busy (no queuing).
module alu_seq #(
  parameter int NBits = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBits-1:0] A,
  input  logic [NBits-1:0] B,
  input  logic [3:0]       FunSel,
  input  logic             start,
  input  logic             WF,
  output logic [NBits-1:0] OutALU,
  output logic [NBits-1:0] OutHi,
  output logic             Zero,
  output logic             Carry,
  output logic             Neg,
  output logic             Ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW  = (NBits > 1) ? $clog2(NBits) : 1;
  localparam int MSB = NBits - 1;

  typedef enum logic {IDLE = 1'b0, MULT = 1'b1} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [NBits-1:0] mcand;
  logic [NBits-1:0] mul_hi;
  logic [NBits-1:0] mul_lo;
  logic             mul_wf;
  logic             mul_last;
  logic [NBits:0]   mul_sum;
  logic [NBits-1:0] mul_hi_nxt;
  logic [NBits-1:0] mul_lo_nxt;

  logic             accept;
  logic [NBits-1:0] alu_res;
  logic [NBits:0]   alu_wide;
  logic             alu_c;
  logic             alu_o;
  logic             upd_c;
  logic             upd_o;

  assign accept   = (state == IDLE) && start;
  assign mul_last = (cnt == CW'(NBits - 1));

  // State register: only IDLE/MULT, cleared asynchronously so reset aborts a MUL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: MUL enters MULT, which leaves after the last shift-add step.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (FunSel == 4'b1111)) state_nxt = MULT;
      MULT:    if (mul_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy covers exactly the NBits MULT cycles.
  always_comb begin
    busy = (state == MULT);
  end

  // One shift-add step: add multiplicand on multiplier LSB, then shift {carry,hi,lo} right.
  always_comb begin
    mul_sum    = {1'b0, mul_hi} + {1'b0, (mul_lo[0] ? mcand : {NBits{1'b0}})};
    mul_hi_nxt = mul_sum[NBits:1];
    mul_lo_nxt = {mul_sum[0], mul_lo[NBits-1:1]};
  end

  // Single-cycle ALU: result plus which of Carry/Ovf this opcode is allowed to touch.
  always_comb begin
    alu_res  = A;
    alu_wide = '0;
    alu_c    = Carry;
    alu_o    = Ovf;
    upd_c    = 1'b0;
    upd_o    = 1'b0;
    case (FunSel)
      4'b0000: alu_res = A;
      4'b0001: alu_res = B;
      4'b0010: alu_res = ~A;
      4'b0011: alu_res = ~B;
      4'b0100, 4'b0101: begin
        alu_wide = {1'b0, A} + {1'b0, B} + {{NBits{1'b0}}, (FunSel[0] & Carry)};
        alu_res  = alu_wide[NBits-1:0];
        alu_c    = alu_wide[NBits];
        alu_o    = (A[MSB] == B[MSB]) && (alu_res[MSB] != A[MSB]);
        upd_c    = 1'b1;
        upd_o    = 1'b1;
      end
      4'b0110: begin
        // MSB of the widened difference is set exactly when A < B (borrow).
        alu_wide = {1'b0, A} - {1'b0, B};
        alu_res  = alu_wide[NBits-1:0];
        alu_c    = alu_wide[NBits];
        alu_o    = (A[MSB] != B[MSB]) && (alu_res[MSB] != A[MSB]);
        upd_c    = 1'b1;
        upd_o    = 1'b1;
      end
      4'b0111: alu_res = A & B;
      4'b1000: alu_res = A | B;
      4'b1001: alu_res = A ^ B;
      4'b1010: begin
        alu_res = {A[MSB-1:0], 1'b0};
        alu_c   = A[MSB];
        alu_o   = A[MSB] ^ A[MSB-1];
        upd_c   = 1'b1;
        upd_o   = 1'b1;
      end
      4'b1011: begin
        alu_res = {1'b0, A[MSB:1]};
        alu_c   = A[0];
        upd_c   = 1'b1;
      end
      4'b1100: begin
        alu_res = {A[MSB], A[MSB:1]};
        alu_c   = A[0];
        upd_c   = 1'b1;
      end
      4'b1101: begin
        alu_res = {A[MSB-1:0], Carry};
        alu_c   = A[MSB];
        upd_c   = 1'b1;
      end
      4'b1110: begin
        alu_res = {Carry, A[MSB:1]};
        alu_c   = A[0];
        upd_c   = 1'b1;
      end
      default: alu_res = A;
    endcase
  end

  // Datapath: result/flag write on accept (single-cycle) or on the final MUL step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OutALU <= '0;
      OutHi  <= '0;
      Zero   <= 1'b0;
      Carry  <= 1'b0;
      Neg    <= 1'b0;
      Ovf    <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mul_hi <= '0;
      mul_lo <= '0;
      mul_wf <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (FunSel == 4'b1111) begin
          mcand  <= A;
          mul_lo <= B;
          mul_hi <= '0;
          mul_wf <= WF;
          cnt    <= '0;
        end else begin
          OutALU <= alu_res;
          OutHi  <= '0;
          done   <= 1'b1;
          if (WF) begin
            Zero <= (alu_res == '0);
            Neg  <= alu_res[MSB];
            if (upd_c) Carry <= alu_c;
            if (upd_o) Ovf   <= alu_o;
          end
        end
      end else if (state == MULT) begin
        mul_hi <= mul_hi_nxt;
        mul_lo <= mul_lo_nxt;
        cnt    <= cnt + CW'(1);
        if (mul_last) begin
          OutALU <= mul_lo_nxt;
          OutHi  <= mul_hi_nxt;
          done   <= 1'b1;
          if (mul_wf) begin
            Zero  <= ({mul_hi_nxt, mul_lo_nxt} == '0);
            Neg   <= mul_hi_nxt[MSB];
            Carry <= (mul_hi_nxt != '0);
            Ovf   <= (mul_hi_nxt != '0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq (NBits=8).
// Latency: inputs driven on falling edges, outputs sampled on falling edges.
// Backpressure: MUL busy window and ignored start pulses are exercised explicitly.
module tb_alu_seq;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] FunSel;
  logic       start;
  logic       WF;
  logic [7:0] OutALU;
  logic [7:0] OutHi;
  logic       Zero;
  logic       Carry;
  logic       Neg;
  logic       Ovf;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  alu_seq #(.NBits(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .FunSel (FunSel),
    .start  (start),
    .WF     (WF),
    .OutALU (OutALU),
    .OutHi  (OutHi),
    .Zero   (Zero),
    .Carry  (Carry),
    .Neg    (Neg),
    .Ovf    (Ovf),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {Zero, Carry, Neg, Ovf};
  endfunction

  // Drive one request on a falling edge; return on the falling edge after the accepting edge.
  task automatic issue(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b,
                       input logic wf);
    FunSel = fs;
    A      = a;
    B      = b;
    WF     = wf;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
  endtask

  // Issue a single-cycle op and check result, OutHi, flags and the done pulse width.
  task automatic op1(input string tag, input logic [3:0] fs, input logic [7:0] a,
                     input logic [7:0] b, input logic wf,
                     input logic [7:0] exp_res, input logic [3:0] exp_flags);
    issue(fs, a, b, wf);
    chk({tag, "_res"}, 32'(OutALU), 32'(exp_res));
    chk({tag, "_hi"}, 32'(OutHi), 32'h0);
    chk({tag, "_flags"}, 32'(flags()), 32'(exp_flags));
    chk({tag, "_done"}, 32'(done), 32'h1);
    @(negedge clk);
    chk({tag, "_done_off"}, 32'(done), 32'h0);
  endtask

  initial begin : main
    int j;
    int busy_cnt;
    int done_seen;
    bit got_done;

    rst = 1'b0; start = 1'b0; A = '0; B = '0; FunSel = '0; WF = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_out", 32'(OutALU), 32'h0);
    chk("rst_hi", 32'(OutHi), 32'h0);
    chk("rst_flags", 32'(flags()), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // flags are {Z,C,N,O}
    op1("add_ovf",  4'b0100, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b0011);
    op1("sub_zero", 4'b0110, 8'h05, 8'h05, 1'b1, 8'h00, 4'b1000);
    op1("sub_brw",  4'b0110, 8'h03, 8'h05, 1'b1, 8'hFE, 4'b0110);
    op1("and_wf0",  4'b0111, 8'h00, 8'hFF, 1'b0, 8'h00, 4'b0110);
    op1("csl",      4'b1101, 8'h80, 8'h00, 1'b1, 8'h01, 4'b0100);
    op1("csr",      4'b1110, 8'h01, 8'h00, 1'b1, 8'h80, 4'b0110);
    op1("adc",      4'b0101, 8'h10, 8'h20, 1'b1, 8'h31, 4'b0000);
    op1("lsl",      4'b1010, 8'hC0, 8'h00, 1'b1, 8'h80, 4'b0110);
    op1("xor_keepc",4'b1001, 8'hF0, 8'hFF, 1'b1, 8'h0F, 4'b0100);
    op1("not_wf0",  4'b0010, 8'h5A, 8'h00, 1'b0, 8'hA5, 4'b0100);

    // MUL 0xFF*0xFF = 0xFE01; start pulses during and at completion must be ignored
    issue(4'b1111, 8'hFF, 8'hFF, 1'b1);
    busy_cnt = 0;
    got_done = 1'b0;
    j = 0;
    while (!got_done && j < 30) begin
      if (done) begin
        got_done = 1'b1;
        chk("mul_latency", 32'(j), 32'd8);
      end else begin
        if (busy) busy_cnt++;
        if (j == 3 || j == 7) begin
          start = 1'b1; FunSel = 4'b0000; A = 8'h33; B = 8'h44; WF = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        j++;
      end
    end
    start = 1'b0;
    chk("mul_got_done", 32'(got_done), 32'h1);
    chk("mul_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("mul_busy_end", 32'(busy), 32'h0);
    chk("mul_lo", 32'(OutALU), 32'h01);
    chk("mul_hi", 32'(OutHi), 32'hFE);
    chk("mul_flags", 32'(flags()), 32'b0111);
    @(negedge clk);
    chk("mul_done_off", 32'(done), 32'h0);
    chk("mul_no_late_accept", 32'(OutALU), 32'h01);

    // Reset asynchronously after the third MUL step: abort with no done pulse
    issue(4'b1111, 8'h03, 8'h05, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mul2_busy", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out", 32'(OutALU), 32'h0);
    chk("arst_hi", 32'(OutHi), 32'h0);
    chk("arst_flags", 32'(flags()), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    chk("arst_no_done", 32'(done_seen), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
